// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive control block:
// FSM state encoding, legal oversampling ratios and reset defaults.
package uart_rx_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_IDLE = 2'd2,
        ST_APPLY     = 2'd3
    } state_t;

    localparam int PRESCALE_W = 6;

    localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
    localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
    localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

    localparam logic [PRESCALE_W-1:0] PRESCALE_DEF = PRESCALE_8;
    localparam logic                  PAR_EN_DEF   = 1'b1;
    localparam logic                  PAR_TYP_DEF  = 1'b0;

    // Only the three supported oversampling ratios are accepted.
    function automatic logic prescale_legal(input logic [PRESCALE_W-1:0] p);
        logic ok;
        case (p)
            PRESCALE_8,
            PRESCALE_16,
            PRESCALE_32: ok = 1'b1;
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_rx_frame_fifo.sv
// Synchronous first-word-fall-through frame buffer. The head entry is
// visible on pop_data whenever the buffer is non-empty and reads as zero
// otherwise. A push into a full buffer is accepted only when a pop happens
// in the same cycle.
module rx_frame_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  wr_en_s;
    logic                  rd_en_s;

    assign full    = (count_r == CW'(FIFO_DEPTH));
    assign empty   = (count_r == {CW{1'b0}});
    assign rd_en_s = pop && !empty;
    assign wr_en_s = push && (!full || rd_en_s);

    assign pop_data = empty ? {DATA_WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Storage array; contents are only observable through a valid head.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control: owns the receiver configuration (applied only
// between frames), gates the receiver enable, buffers frames and keeps
// saturating error/overflow statistics.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_en,
    input  logic                  cfg_wr,
    input  logic [5:0]            cfg_prescale,
    input  logic                  cfg_par_en,
    input  logic                  cfg_par_typ,
    output logic                  cfg_rej,
    output logic                  cfg_pending,
    input  logic                  rx_busy,
    output logic                  rx_enable,
    output logic [5:0]            rx_prescale,
    output logic                  rx_par_en,
    output logic                  rx_par_typ,
    input  logic                  rx_data_valid,
    input  logic [DATA_WIDTH-1:0] rx_p_data,
    input  logic                  rx_par_err,
    input  logic                  rx_stp_err,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  clr_cnt,
    output logic [CNT_W-1:0]      par_err_cnt,
    output logic [CNT_W-1:0]      stp_err_cnt,
    output logic [CNT_W-1:0]      ovf_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t          state_r;
    state_t          state_next_s;
    logic            rx_enable_r;
    logic [5:0]      rx_prescale_r;
    logic            rx_par_en_r;
    logic            rx_par_typ_r;
    logic [5:0]      pend_prescale_r;
    logic            pend_par_en_r;
    logic            pend_par_typ_r;
    logic            cfg_pending_r;
    logic            cfg_rej_r;
    logic            cfg_accept_s;
    logic            push_req_s;
    logic            pop_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            drop_s;
    logic [CNT_W-1:0] par_err_cnt_r;
    logic [CNT_W-1:0] stp_err_cnt_r;
    logic [CNT_W-1:0] ovf_cnt_r;

    assign cfg_accept_s = cfg_wr && prescale_legal(cfg_prescale);
    assign push_req_s   = rx_data_valid && (state_r != ST_OFF);
    assign pop_s        = out_ready && !fifo_empty_s;
    assign drop_s       = push_req_s && fifo_full_s && !pop_s;

    assign rx_enable   = rx_enable_r;
    assign rx_prescale = rx_prescale_r;
    assign rx_par_en   = rx_par_en_r;
    assign rx_par_typ  = rx_par_typ_r;
    assign cfg_pending = cfg_pending_r;
    assign cfg_rej     = cfg_rej_r;
    assign out_valid   = !fifo_empty_s;
    assign par_err_cnt = par_err_cnt_r;
    assign stp_err_cnt = stp_err_cnt_r;
    assign ovf_cnt     = ovf_cnt_r;

    // Next-state logic; a pending config always gets applied before OFF.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_OFF: begin
                if (ctrl_en) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_OFF;
                end
            end
            ST_RUN: begin
                if (cfg_pending_r) begin
                    state_next_s = rx_busy ? ST_WAIT_IDLE : ST_APPLY;
                end else if (!ctrl_en && !rx_busy) begin
                    state_next_s = ST_OFF;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_WAIT_IDLE: begin
                if (!rx_busy) begin
                    state_next_s = ST_APPLY;
                end else begin
                    state_next_s = ST_WAIT_IDLE;
                end
            end
            ST_APPLY: begin
                state_next_s = ctrl_en ? ST_RUN : ST_OFF;
            end
            default: begin
                state_next_s = ST_OFF;
            end
        endcase
    end

    // State register; the enable is registered from the next state so it
    // tracks the state decode without a combinational output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_OFF;
            rx_enable_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            rx_enable_r <= (state_next_s == ST_RUN) || (state_next_s == ST_WAIT_IDLE);
        end
    end

    // Config shadowing: direct apply while OFF, otherwise stage as pending.
    // A write landing in the APPLY cycle becomes the next pending config.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_prescale_r   <= PRESCALE_DEF;
            rx_par_en_r     <= PAR_EN_DEF;
            rx_par_typ_r    <= PAR_TYP_DEF;
            pend_prescale_r <= PRESCALE_DEF;
            pend_par_en_r   <= PAR_EN_DEF;
            pend_par_typ_r  <= PAR_TYP_DEF;
            cfg_pending_r   <= 1'b0;
            cfg_rej_r       <= 1'b0;
        end else begin
            cfg_rej_r <= cfg_wr && !prescale_legal(cfg_prescale);
            if (state_r == ST_APPLY) begin
                rx_prescale_r <= pend_prescale_r;
                rx_par_en_r   <= pend_par_en_r;
                rx_par_typ_r  <= pend_par_typ_r;
            end
            if (cfg_accept_s) begin
                if (state_r == ST_OFF) begin
                    rx_prescale_r <= cfg_prescale;
                    rx_par_en_r   <= cfg_par_en;
                    rx_par_typ_r  <= cfg_par_typ;
                    cfg_pending_r <= 1'b0;
                end else begin
                    pend_prescale_r <= cfg_prescale;
                    pend_par_en_r   <= cfg_par_en;
                    pend_par_typ_r  <= cfg_par_typ;
                    cfg_pending_r   <= 1'b1;
                end
            end else if (state_r == ST_APPLY) begin
                cfg_pending_r <= 1'b0;
            end
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_cnt_r <= {CNT_W{1'b0}};
            stp_err_cnt_r <= {CNT_W{1'b0}};
            ovf_cnt_r     <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            par_err_cnt_r <= {CNT_W{1'b0}};
            stp_err_cnt_r <= {CNT_W{1'b0}};
            ovf_cnt_r     <= {CNT_W{1'b0}};
        end else begin
            if (rx_par_err) begin
                par_err_cnt_r <= sat_inc(par_err_cnt_r);
            end
            if (rx_stp_err) begin
                stp_err_cnt_r <= sat_inc(stp_err_cnt_r);
            end
            if (drop_s) begin
                ovf_cnt_r <= sat_inc(ovf_cnt_r);
            end
        end
    end

    rx_frame_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req_s),
        .push_data (rx_p_data),
        .pop       (pop_s),
        .pop_data  (out_data),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl. Expected frames are queued when
// pushed; a negedge monitor compares every handshake against the queue.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ctrl_en;
    logic       cfg_wr;
    logic [5:0] cfg_prescale;
    logic       cfg_par_en;
    logic       cfg_par_typ;
    logic       cfg_rej;
    logic       cfg_pending;
    logic       rx_busy;
    logic       rx_enable;
    logic [5:0] rx_prescale;
    logic       rx_par_en;
    logic       rx_par_typ;
    logic       rx_data_valid;
    logic [7:0] rx_p_data;
    logic       rx_par_err;
    logic       rx_stp_err;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       clr_cnt;
    logic [7:0] par_err_cnt;
    logic [7:0] stp_err_cnt;
    logic [7:0] ovf_cnt;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    uart_rx_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .ctrl_en(ctrl_en), .cfg_wr(cfg_wr),
        .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en),
        .cfg_par_typ(cfg_par_typ), .cfg_rej(cfg_rej), .cfg_pending(cfg_pending),
        .rx_busy(rx_busy), .rx_enable(rx_enable), .rx_prescale(rx_prescale),
        .rx_par_en(rx_par_en), .rx_par_typ(rx_par_typ),
        .rx_data_valid(rx_data_valid), .rx_p_data(rx_p_data),
        .rx_par_err(rx_par_err), .rx_stp_err(rx_stp_err),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .clr_cnt(clr_cnt), .par_err_cnt(par_err_cnt),
        .stp_err_cnt(stp_err_cnt), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted output word must match the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL fifo_unexpected: got 0x%0h, expected no data", out_data);
            end else begin
                exp_v = exp_q.pop_front();
                check("fifo_data", 32'(out_data), 32'(exp_v));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ctrl_en = 1'b1; cfg_wr = 1'b0; cfg_prescale = 6'd0;
        cfg_par_en = 1'b0; cfg_par_typ = 1'b0; rx_busy = 1'b0;
        rx_data_valid = 1'b0; rx_p_data = 8'h00; rx_par_err = 1'b0;
        rx_stp_err = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_rx_enable",   32'(rx_enable),   32'd0);
        check("rst_rx_prescale", 32'(rx_prescale), 32'd8);
        check("rst_rx_par_en",   32'(rx_par_en),   32'd1);
        check("rst_rx_par_typ",  32'(rx_par_typ),  32'd0);
        check("rst_cfg_pending", 32'(cfg_pending), 32'd0);
        check("rst_cfg_rej",     32'(cfg_rej),     32'd0);
        check("rst_out_valid",   32'(out_valid),   32'd0);
        check("rst_out_data",    32'(out_data),    32'd0);
        check("rst_counters",    {8'd0, par_err_cnt, stp_err_cnt, ovf_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        check("run_rx_enable", 32'(rx_enable), 32'd1);

        // Config deferred while busy
        rx_busy = 1'b1; cfg_wr = 1'b1; cfg_prescale = 6'd16; cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
        tick();
        cfg_wr = 1'b0;
        check("busy_cfg_pending", 32'(cfg_pending), 32'd1);
        check("busy_prescale",    32'(rx_prescale), 32'd8);
        repeat (2) tick();
        check("wait_prescale", 32'(rx_prescale), 32'd8);
        check("wait_enable",   32'(rx_enable),   32'd1);
        rx_busy = 1'b0;
        tick();
        check("apply_enable",  32'(rx_enable),   32'd0);
        check("apply_pending", 32'(cfg_pending), 32'd1);
        tick();
        check("post_apply_prescale", 32'(rx_prescale), 32'd16);
        check("post_apply_par_en",   32'(rx_par_en),   32'd0);
        check("post_apply_pending",  32'(cfg_pending), 32'd0);
        check("post_apply_enable",   32'(rx_enable),   32'd1);

        // Illegal prescale rejected
        cfg_wr = 1'b1; cfg_prescale = 6'd12; cfg_par_en = 1'b1; cfg_par_typ = 1'b1;
        tick();
        cfg_wr = 1'b0;
        check("rej_pulse",    32'(cfg_rej),     32'd1);
        check("rej_pending",  32'(cfg_pending), 32'd0);
        tick();
        check("rej_pulse_end", 32'(cfg_rej),     32'd0);
        check("rej_prescale",  32'(rx_prescale), 32'd16);
        check("rej_par_typ",   32'(rx_par_typ),  32'd0);

        // Config while idle: RUN -> APPLY -> RUN
        cfg_wr = 1'b1; cfg_prescale = 6'd32; cfg_par_en = 1'b1; cfg_par_typ = 1'b1;
        tick();
        cfg_wr = 1'b0;
        tick();
        check("idle_apply_enable", 32'(rx_enable), 32'd0);
        tick();
        check("idle_prescale", 32'(rx_prescale), 32'd32);
        check("idle_par_typ",  32'(rx_par_typ),  32'd1);

        // Fill FIFO with overflow
        for (int i = 1; i <= 5; i++) begin
            rx_data_valid = 1'b1;
            rx_p_data = 8'(i * 17);
            if (i <= 4) exp_q.push_back(8'(i * 17));
            tick();
        end
        rx_data_valid = 1'b0;
        check("ovf_after_fill", 32'(ovf_cnt),   32'd1);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_head",      32'(out_data),  32'h11);

        // Simultaneous push and pop on a full FIFO
        out_ready = 1'b1; rx_data_valid = 1'b1; rx_p_data = 8'h66;
        exp_q.push_back(8'h66);
        tick();
        out_ready = 1'b0; rx_data_valid = 1'b0;
        check("pushpop_ovf",  32'(ovf_cnt),  32'd1);
        check("pushpop_head", 32'(out_data), 32'h22);
        rx_data_valid = 1'b1; rx_p_data = 8'h77;
        tick();
        rx_data_valid = 1'b0;
        check("still_full_ovf", 32'(ovf_cnt), 32'd2);

        // Drain
        out_ready = 1'b1;
        for (int i = 0; i < 20 && out_valid; i++) tick();
        repeat (2) tick();
        out_ready = 1'b0;
        check("drain_out_valid", 32'(out_valid),    32'd0);
        check("drain_out_data",  32'(out_data),     32'd0);
        check("drain_all_seen",  32'(exp_q.size()), 32'd0);

        // Saturating counters and clear priority
        rx_par_err = 1'b1;
        repeat (300) tick();
        rx_par_err = 1'b0;
        check("par_err_sat", 32'(par_err_cnt), 32'd255);
        for (int i = 0; i < 3; i++) begin
            rx_stp_err = 1'b1; tick();
            rx_stp_err = 1'b0; tick();
        end
        check("stp_err_3", 32'(stp_err_cnt), 32'd3);
        clr_cnt = 1'b1; rx_stp_err = 1'b1;
        tick();
        clr_cnt = 1'b0; rx_stp_err = 1'b0;
        check("clr_stp", 32'(stp_err_cnt), 32'd0);
        check("clr_par", 32'(par_err_cnt), 32'd0);
        check("clr_ovf", 32'(ovf_cnt),     32'd0);

        // OFF: pushes ignored, config applied directly
        ctrl_en = 1'b0;
        tick();
        check("off_enable", 32'(rx_enable), 32'd0);
        rx_data_valid = 1'b1; rx_p_data = 8'h99;
        tick();
        rx_data_valid = 1'b0;
        tick();
        check("off_no_push", 32'(out_valid), 32'd0);
        cfg_wr = 1'b1; cfg_prescale = 6'd16; cfg_par_en = 1'b1; cfg_par_typ = 1'b0;
        tick();
        cfg_wr = 1'b0;
        check("off_direct_prescale", 32'(rx_prescale), 32'd16);
        check("off_direct_par_typ",  32'(rx_par_typ),  32'd0);
        check("off_direct_pending",  32'(cfg_pending), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
